spi_host_ctrl: RTL

- CPU-side sequencer sitting directly upstream of the 8-bit SPI shift stage. It owns a small register file on the CPU2908 I/O bus.
- It drives the shift stage's parallel-load, start and mode strobes. It captures the received byte when the stage reports Done.
- It also provides slave-select outputs, a timeout and an interrupt.

---
 rtl/spi_host_ctrl.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_host_ctrl.sv
// Purpose : CPU-side sequencer in front of an 8-bit SPI shift stage (load, arm, run, capture).
// Latency : bus_rdata one cycle after bus_sel; DATA write to done_flag is 2 + ARM_CYC + RUN + 1 cycles.
// Backpressure: none on the bus; a DATA write while busy is dropped and flagged in ovr.
//
// Ports:
//   clk, reset          system clock (shared with the shift stage), synchronous active-high reset
//   bus_sel/we/addr     one-cycle register access strobe; addr 0 = DATA, 1 = CTRL/STATUS
//   bus_wdata/rdata     write data / registered read data
//   irq                 level interrupt = done_flag & irq_en
//   spi_in, spi_LorS, spi_LClock, spi_nStart
//                       parallel byte, load/shift select, register strobe, active-low start
//   spi_Done, spi_out   completion (asynchronous to clk) and received byte
//   ss_n                active-low slave selects
//
// CTRL/STATUS layout: [7] ovr W1C, [6] ss_force, [5:4] ss_sel, [3] tmo W1C,
//                     [2] irq_en, [1] done_flag W1C, [0] busy RO.

`timescale 1ns/1ps

module spi_host_ctrl #(
    parameter int NUM_SS      = 2,
    parameter int TIMEOUT_CYC = 64,
    parameter int ARM_CYC     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_sel,
    input  logic              bus_we,
    input  logic              bus_addr,
    input  logic [7:0]        bus_wdata,
    output logic [7:0]        bus_rdata,
    output logic              irq,
    output logic [7:0]        spi_in,
    output logic              spi_LorS,
    output logic              spi_LClock,
    output logic              spi_nStart,
    input  logic              spi_Done,
    input  logic [7:0]        spi_out,
    output logic [NUM_SS-1:0] ss_n
);

    // One counter serves LOAD (2 cycles), ARM and the RUN timeout.
    localparam int CW = $clog2(TIMEOUT_CYC + ARM_CYC + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_RUN,
        S_CAPT
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;

    logic          r_done_s1;
    logic          r_done_s2;

    logic [7:0]    r_tx;
    logic [7:0]    r_rx;
    logic [7:0]    r_rdata;
    logic          r_ovr;
    logic          r_ss_force;
    logic [1:0]    r_ss_sel;
    logic          r_tmo;
    logic          r_irq_en;
    logic          r_done_flag;

    logic          w_busy;
    logic          w_wr_data;
    logic          w_wr_ctrl;
    logic          w_rd;
    logic          w_start;
    logic          w_tmo_set;
    logic          w_capt;
    logic [7:0]    w_status;

    // spi_Done comes from another timing domain; only r_done_s2 is used.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done_s1 <= 1'b0;
            r_done_s2 <= 1'b0;
        end else begin
            r_done_s1 <= spi_Done;
            r_done_s2 <= r_done_s1;
        end
    end

    assign w_wr_data = bus_sel & bus_we & ~bus_addr;
    assign w_wr_ctrl = bus_sel & bus_we & bus_addr;
    assign w_rd      = bus_sel & ~bus_we;
    assign w_busy    = (r_state != S_IDLE);
    assign w_start   = w_wr_data & ~w_busy;

    // State register; the counter restarts on every state change.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Next state and shift-stage strobes. IDLE outputs equal the reset values,
    // so a synchronous reset returns the stage to "held clear" within one cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_tmo_set   = 1'b0;
        w_capt      = 1'b0;
        spi_LorS    = 1'b1;
        spi_LClock  = 1'b0;
        spi_nStart  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                // First cycle presents the byte with LorS low, second clocks it in.
                spi_LorS = 1'b0;
                if (r_cnt == CW'(1)) begin
                    spi_LClock  = 1'b1;
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                if (r_cnt == CW'(ARM_CYC - 1)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                spi_nStart = 1'b1;
                spi_LClock = 1'b1;
                // Done is checked first so it wins over a same-cycle timeout.
                if (r_done_s2) begin
                    w_state_nxt = S_CAPT;
                end else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
                    w_tmo_set   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_CAPT: begin
                spi_nStart  = 1'b1;
                w_capt      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_status = {r_ovr, r_ss_force, r_ss_sel, r_tmo, r_irq_en, r_done_flag, w_busy};

    // Register file. Hardware set events are applied after W1C clears so the set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx        <= 8'h00;
            r_rx        <= 8'h00;
            r_rdata     <= 8'h00;
            r_ovr       <= 1'b0;
            r_ss_force  <= 1'b0;
            r_ss_sel    <= 2'b00;
            r_tmo       <= 1'b0;
            r_irq_en    <= 1'b0;
            r_done_flag <= 1'b0;
        end else begin
            if (w_start) begin
                r_tx <= bus_wdata;
            end
            if (w_wr_data && w_busy) begin
                r_ovr <= 1'b1;
            end
            if (w_wr_ctrl) begin
                if (bus_wdata[7]) begin
                    r_ovr <= 1'b0;
                end
                r_ss_force <= bus_wdata[6];
                // Retargeting the select mid-transfer would glitch the active slave.
                if (!w_busy) begin
                    r_ss_sel <= bus_wdata[5:4];
                end
                if (bus_wdata[3]) begin
                    r_tmo <= 1'b0;
                end
                r_irq_en <= bus_wdata[2];
                if (bus_wdata[1]) begin
                    r_done_flag <= 1'b0;
                end
            end
            if (w_tmo_set) begin
                r_tmo <= 1'b1;
            end
            if (w_capt) begin
                r_rx        <= spi_out;
                r_done_flag <= 1'b1;
            end
            // Reads see pre-edge values, so a DATA read during CAPT returns the old byte.
            if (w_rd) begin
                r_rdata <= bus_addr ? w_status : r_rx;
            end
        end
    end

    // Out-of-range ss_sel simply matches no bit.
    always_comb begin
        ss_n = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if ((w_busy || r_ss_force) && (r_ss_sel == 2'(i))) begin
                ss_n[i] = 1'b0;
            end
        end
    end

    assign bus_rdata = r_rdata;
    assign irq       = r_done_flag & r_irq_en;
    assign spi_in    = r_tx;

endmodule
